// File: rtl/rgb2y_frame_ctrl_if.sv
// rgb2y_frame_ctrl_if: FIFO-side bundle of the RGB-to-luma frame sequencer.
// Groups the source, converter and sink FWFT FIFO signals; master = controller.
interface rgb2y_frame_ctrl_if;
    logic [31:0] src_dout;
    logic        src_empty;
    logic        src_rd_en;
    logic        cv_srst;
    logic [31:0] cv_din;
    logic        cv_wr_en;
    logic        cv_full;
    logic [31:0] cv_dout;
    logic        cv_empty;
    logic        cv_rd_en;
    logic [31:0] snk_din;
    logic        snk_wr_en;
    logic        snk_full;

    modport master (
        input  src_dout, src_empty, cv_full, cv_dout, cv_empty, snk_full,
        output src_rd_en, cv_srst, cv_din, cv_wr_en, cv_rd_en,
        output snk_din, snk_wr_en
    );

    modport slave (
        output src_dout, src_empty, cv_full, cv_dout, cv_empty, snk_full,
        input  src_rd_en, cv_srst, cv_din, cv_wr_en, cv_rd_en,
        input  snk_din, snk_wr_en
    );
endinterface

// File: rtl/rgb2y_frame_ctrl.sv
// rgb2y_frame_ctrl: frame sequencer feeding N RGB pixels through the luma
// converter under credit control and packing 4 Y bytes per sink word.
// Ports: clk, srst_n (sync, active low), start/pix_num (frame request),
// busy/done (status), frame_cycles (stats), bus (src/cv/snk FIFO master).
// Optional RGB2Y_FRAME_STATS_EN: saturating frame cycle counter.
module rgb2y_frame_ctrl #(
    parameter int CREDITS = 14,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             srst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] pix_num,
    output logic             busy,
    output logic             done,
    output logic [31:0]      frame_cycles,
    rgb2y_frame_ctrl_if.master bus
);
    localparam int IW = $clog2(CREDITS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] num;
    logic [CNT_W-1:0] issued;
    logic [CNT_W-1:0] received;
    logic [IW-1:0]    inflight;
    logic [1:0]       lane;
    logic             word_valid;
    logic [31:0]      acc;

    logic issue;
    logic pop;
    logic snk_wr;
    logic last_pix;
    logic unused_bits;

    // Enables are gated by reset so nothing moves during the flush cycle.
    assign issue = srst_n && state == S_RUN && issued < num
                   && !bus.src_empty && !bus.cv_full
                   && inflight < IW'(CREDITS);
    assign pop = srst_n && (state == S_RUN || state == S_FLUSH)
                 && !bus.cv_empty && !word_valid && received < num;
    assign snk_wr = srst_n && word_valid && !bus.snk_full;
    assign last_pix = received == num - CNT_W'(1);

    assign bus.src_rd_en = issue;
    assign bus.cv_wr_en  = issue;
    assign bus.cv_din    = bus.src_dout;
    assign bus.cv_srst   = ~srst_n;
    assign bus.cv_rd_en  = pop;
    assign bus.snk_wr_en = snk_wr;
    assign bus.snk_din   = acc;

    assign unused_bits = ^bus.cv_dout[31:8];

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            state      <= S_IDLE;
            num        <= '0;
            issued     <= '0;
            received   <= '0;
            inflight   <= '0;
            lane       <= '0;
            word_valid <= 1'b0;
            acc        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (issue) begin
                issued <= issued + 1'b1;
            end
            if (issue && !pop) begin
                inflight <= inflight + 1'b1;
            end else if (!issue && pop) begin
                inflight <= inflight - 1'b1;
            end
            // pop needs !word_valid and snk_wr needs word_valid: exclusive.
            if (snk_wr) begin
                word_valid <= 1'b0;
                acc        <= '0;
            end
            if (pop) begin
                acc[8*lane +: 8] <= bus.cv_dout[7:0];
                received         <= received + 1'b1;
                if (lane == 2'd3 || last_pix) begin
                    word_valid <= 1'b1;
                    lane       <= '0;
                end else begin
                    lane <= lane + 1'b1;
                end
            end
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        num      <= pix_num;
                        issued   <= '0;
                        received <= '0;
                        if (pix_num == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (issued == num) begin
                        state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (received == num && !word_valid) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef RGB2Y_FRAME_STATS_EN
    logic [31:0] cyc_cnt;
    logic [31:0] fc_q;

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            cyc_cnt <= '0;
            fc_q    <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                cyc_cnt <= '0;
            end else if ((state == S_RUN || state == S_FLUSH)
                         && cyc_cnt != '1) begin
                cyc_cnt <= cyc_cnt + 1'b1;
            end
            if (state == S_DONE) begin
                fc_q <= cyc_cnt;
            end
        end
    end

    assign frame_cycles = fc_q;
`else
    assign frame_cycles = '0;
`endif
endmodule

// File: tb/tb_rgb2y_frame_ctrl.sv
// tb_rgb2y_frame_ctrl: randomized self-checking bench with a behavioural
// converter/FIFO environment and a packed-word scoreboard.
module tb_rgb2y_frame_ctrl;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             srst_n = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] pix_num = '0;
    logic             busy;
    logic             done;
    logic [31:0]      frame_cycles;

    rgb2y_frame_ctrl_if bus();

    rgb2y_frame_ctrl #(.CREDITS(14), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .srst_n(srst_n),
        .start(start),
        .pix_num(pix_num),
        .busy(busy),
        .done(done),
        .frame_cycles(frame_cycles),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pix[$];
    int src_q[$];
    int exp_q[$];
    int conv_y[$];
    int conv_t[$];
    int cyc = 0;
    int nframe = 0;
    int frame_pops = 0;
    bit pending = 0;
    int done_cnt = 0;
    int busy_cyc = 0;
    int n_issue = 0;
    int n_words = 0;
    int snk_hold = 0;
    bit src_rand = 0;
    bit snk_rand = 0;
    bit cv_rand = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Y = (77R + 150G + 29B) / 256
    function automatic logic [7:0] luma(input logic [31:0] p);
        int s;
        s = 77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0]);
        return s[15:8];
    endfunction

    task automatic load_frame();
        logic [31:0] w;
        int n;
        n = pix.size();
        nframe = n;
        src_q = pix;
        exp_q.delete();
        w = '0;
        for (int i = 0; i < n; i++) begin
            w[8*(i%4) +: 8] = luma(pix[i]);
            if (i % 4 == 3 || i == n - 1) begin
                exp_q.push_back(w);
                w = '0;
            end
        end
        frame_pops = 0;
        pending = 0;
        done_cnt = 0;
        busy_cyc = 0;
        n_issue = 0;
        n_words = 0;
    endtask

    task automatic clear_model();
        src_q.delete();
        exp_q.delete();
        pending = 0;
        frame_pops = 0;
    endtask

    // Environment: source FIFO, converter (>=3 cycle latency), sink.
    initial begin
        logic s_cw, s_cr, s_sw, s_rst;
        logic [31:0] s_sd, s_din;
        bus.src_empty = 1'b1;
        bus.src_dout  = '0;
        bus.cv_full   = 1'b0;
        bus.cv_empty  = 1'b1;
        bus.cv_dout   = '0;
        bus.snk_full  = 1'b0;
        forever begin
            @(negedge clk);
            s_cw  = bus.cv_wr_en;
            s_cr  = bus.cv_rd_en;
            s_sw  = bus.snk_wr_en;
            s_sd  = bus.snk_din;
            s_din = bus.cv_din;
            s_rst = bus.cv_srst;
            chk("cv_srst", bus.cv_srst, !srst_n);
            chk("rd_wr_tie", bus.src_rd_en, s_cw);
            chk("cv_din", s_din, bus.src_dout);
            if (s_cw) chk("issue_gate", {bus.src_empty, bus.cv_full}, 0);
            if (s_cr) chk("pop_gate", {pending, bus.cv_empty}, 0);
            if (s_sw) chk("snk_gate", bus.snk_full, 0);
            chk("inflight", conv_y.size() <= 14, 1);
            if (done) done_cnt++;
            if (busy) busy_cyc++;
            @(posedge clk);
            #1;
            cyc++;
            if (s_rst) begin
                conv_y.delete();
                conv_t.delete();
            end else begin
                if (s_cw) begin
                    conv_y.push_back(int'(luma(s_din)));
                    conv_t.push_back(cyc + 3);
                    if (src_q.size() > 0) void'(src_q.pop_front());
                    n_issue++;
                end
                if (s_cr) begin
                    void'(conv_y.pop_front());
                    void'(conv_t.pop_front());
                    frame_pops++;
                    if (frame_pops % 4 == 0 || frame_pops == nframe)
                        pending = 1;
                end
                if (s_sw) begin
                    chk("snk_pending", pending, 1);
                    if (exp_q.size() > 0) begin
                        chk("snk_word", s_sd, exp_q.pop_front());
                    end else begin
                        checks++;
                        errors++;
                        $display("FAIL snk_extra: got %h expected none", s_sd);
                    end
                    pending = 0;
                    n_words++;
                end
            end
            if (src_q.size() > 0) begin
                bus.src_dout  = src_q[0] & 32'h00FF_FFFF;
                bus.src_empty = src_rand && $urandom_range(0, 2) == 0;
            end else begin
                bus.src_dout  = $urandom;
                bus.src_empty = 1'b1;
            end
            bus.cv_full = conv_y.size() >= 16
                          || (cv_rand && $urandom_range(0, 3) == 0);
            bus.cv_dout = $urandom;
            if (conv_y.size() > 0 && conv_t[0] <= cyc) begin
                bus.cv_empty     = 1'b0;
                bus.cv_dout[7:0] = conv_y[0][7:0];
            end else begin
                bus.cv_empty = 1'b1;
            end
            if (snk_hold > 0) begin
                bus.snk_full = 1'b1;
                snk_hold--;
            end else begin
                bus.snk_full = snk_rand && $urandom_range(0, 2) == 0;
            end
        end
    end

    task automatic pulse_reset();
        @(posedge clk);
        #2;
        srst_n = 1'b0;
        @(posedge clk);
        #2;
        srst_n = 1'b1;
        clear_model();
    endtask

    task automatic run_frame(input int hold_at, input bit ign_start);
        int n;
        bit held;
        bit ok;
        n = nframe;
        held = 0;
        ok = 0;
        @(posedge clk);
        #2;
        start = 1'b1;
        pix_num = CNT_W'(n);
        @(posedge clk);
        #2;
        start = 1'b0;
        pix_num = CNT_W'($urandom);
        if (n == 0) begin
            @(negedge clk);
            chk("zero_done", {done, busy}, 2'b10);
            @(negedge clk);
            chk("zero_done_pulse", done, 0);
        end else begin
            @(negedge clk);
            chk("busy_run", busy, 1);
        end
        for (int t = 0; t < 4000; t++) begin
            @(posedge clk);
            #2;
            start = 1'b0;
            if (done_cnt > 0) begin
                ok = 1;
                break;
            end
            if (hold_at >= 0 && !held && frame_pops >= hold_at) begin
                snk_hold = 40;
                held = 1;
            end
            if (ign_start && t == 10) begin
                start = 1'b1;
                pix_num = 3;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: got no done expected done n=%0d", n);
            pulse_reset();
        end else begin
            repeat (3) @(posedge clk);
            @(negedge clk);
            chk("done_once", done_cnt, 1);
            chk("busy_after", busy, 0);
            chk("issues", n_issue, n);
            chk("words", n_words, (n + 3) / 4);
            chk("exp_left", exp_q.size(), 0);
            chk("conv_left", conv_y.size(), 0);
`ifdef RGB2Y_FRAME_STATS_EN
            chk("frame_cycles", frame_cycles, busy_cyc);
            if (n > 0) chk("frame_cycles_nz", frame_cycles != 0, 1);
`else
            chk("frame_cycles_off", frame_cycles, 0);
`endif
        end
    endtask

    task automatic test1_pixels();
        pix = '{32'hFFFFFF, 32'h000000, 32'hFF0000, 32'h00FF00};
        load_frame();
        chk("model_t1", exp_q[0], 32'h954C00FF);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #2;
        srst_n = 1'b1;
        clear_model();
        @(negedge clk);
        chk("rst_state", {busy, done, bus.src_rd_en, bus.cv_rd_en,
                          bus.snk_wr_en}, 0);
        chk("rst_snk_din", bus.snk_din, 0);
        chk("rst_fc", frame_cycles, 0);

        test1_pixels();
        run_frame(-1, 0);

        pix.delete();
        repeat (5) pix.push_back(32'h00FFFFFF);
        load_frame();
        chk("model_t2a", exp_q[0], 32'hFFFFFFFF);
        chk("model_t2b", exp_q[1], 32'h000000FF);
        run_frame(-1, 0);

        pix.delete();
        load_frame();
        run_frame(-1, 0);

        pix.delete();
        for (int i = 0; i < 64; i++) pix.push_back((i * 32'h030201) & 32'hFFFFFF);
        load_frame();
        run_frame(20, 0);

        src_rand = 1;
        pix.delete();
        for (int i = 0; i < 32; i++) pix.push_back($urandom & 32'hFFFFFF);
        load_frame();
        run_frame(-1, 1);

        pix.delete();
        for (int i = 0; i < 32; i++) pix.push_back($urandom & 32'hFFFFFF);
        load_frame();
        @(posedge clk);
        #2;
        start = 1'b1;
        pix_num = 32;
        @(posedge clk);
        #2;
        start = 1'b0;
        for (int t = 0; t < 500 && n_issue < 10; t++) begin
            @(posedge clk);
            #2;
        end
        chk("rst_issued", n_issue, 10);
        srst_n = 1'b0;
        @(negedge clk);
        chk("rst_cv_srst", bus.cv_srst, 1);
        chk("rst_en_low", {bus.src_rd_en, bus.cv_rd_en, bus.snk_wr_en}, 0);
        @(posedge clk);
        #2;
        srst_n = 1'b1;
        clear_model();
        @(negedge clk);
        chk("rst_mid_state", {busy, done, bus.src_rd_en, bus.cv_wr_en,
                              bus.cv_rd_en, bus.snk_wr_en}, 0);
        chk("rst_mid_snk_din", bus.snk_din, 0);
        chk("rst_mid_fc", frame_cycles, 0);
        src_rand = 0;
        test1_pixels();
        run_frame(-1, 0);

        src_rand = 1;
        snk_rand = 1;
        cv_rand = 1;
        for (int f = 0; f < 5; f++) begin
            n = $urandom_range(1, 40);
            pix.delete();
            for (int i = 0; i < n; i++) pix.push_back($urandom & 32'hFFFFFF);
            load_frame();
            run_frame(f == 2 ? 8 : -1, f == 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
